// File: rtl/toaplan2_rom_arbiter_if.sv
// Bundle of the client-side read ports and the SDRAM bank port of the
// ROM arbiter. The "slave" view belongs to the arbiter; the "master" view
// belongs to whatever drives the clients and models the bank.
interface toaplan2_rom_arbiter_if #(
    parameter int N  = 4,
    parameter int AW = 22,
    parameter int DW = 32
);
    // client side
    logic [N-1:0]    cs;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    ok;
    logic [N*DW-1:0] dout;

    // SDRAM bank side
    logic [AW-1:0]   ba_addr;
    logic            ba_rd;
    logic            ba_ack;
    logic            ba_dst;
    logic            ba_dok;
    logic            ba_rdy;
    logic [15:0]     data_read;

    modport slave (
        input  cs, addr, ba_ack, ba_dst, ba_dok, ba_rdy, data_read,
        output ok, dout, ba_addr, ba_rd
    );

    modport master (
        output cs, addr, ba_ack, ba_dst, ba_dok, ba_rdy, data_read,
        input  ok, dout, ba_addr, ba_rd
    );
endinterface

// File: rtl/toaplan2_rom_arbiter.sv
// Round-robin SDRAM read arbiter with a one-entry cache per ROM client.
// Each client word (DW bits) is assembled from DW/16 consecutive 16-bit
// bank beats; a client hits when its cached entry is valid and its tag
// matches the requested address.
module toaplan2_rom_arbiter #(
    parameter int              N      = 4,
    parameter int              AW     = 22,
    parameter int              DW     = 32,
    parameter logic [N*AW-1:0] OFFSET = '0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_downloading,
    input  logic i_flush,
    output logic o_busy,
    toaplan2_rom_arbiter_if.slave bus
);
    localparam int BEATS = DW / 16;
    localparam int BSH   = (BEATS == 1) ? 0 : $clog2(BEATS);
    localparam int GW    = $clog2(N);
    localparam int GW1   = GW + 1;
    localparam int BW    = $clog2(BEATS + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_tag   [N];
    logic [DW-1:0]   r_data  [N];
    logic [N-1:0]    r_valid;
    logic [GW-1:0]   r_gnt;
    logic [GW-1:0]   r_last;
    logic [AW-1:0]   r_laddr;
    logic [AW-1:0]   r_ba_addr;
    logic            r_ba_rd;
    logic [BW-1:0]   r_beat;
    logic [DW-1:0]   r_buf;

    logic [N-1:0]    w_hit;
    logic [N-1:0]    w_miss;
    logic            w_pick_any;
    logic [GW-1:0]   w_pick;
    logic [AW-1:0]   w_pick_addr;
    logic [AW-1:0]   w_pick_off;
    logic [AW-1:0]   w_req_addr;
    logic [BW-1:0]   w_beat_idx;
    logic            w_cap;
    logic [DW-1:0]   w_buf_next;

    // Per-client hit/miss and outputs; DOUT always shows the cached word
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_client
            assign w_hit[gi]   = r_valid[gi] && (bus.addr[gi*AW +: AW] == r_tag[gi]);
            assign w_miss[gi]  = bus.cs[gi] && !w_hit[gi];
            assign bus.ok[gi]  = bus.cs[gi] && w_hit[gi] && !i_downloading;
            assign bus.dout[gi*DW +: DW] = r_data[gi];
        end
    endgenerate

    // Round-robin pick: first missing client after the last one served
    always_comb begin
        logic [GW1-1:0] v_sum;
        logic [GW-1:0]  v_idx;
        v_sum      = '0;
        v_idx      = '0;
        w_pick_any = 1'b0;
        w_pick     = '0;
        for (int k = 1; k <= N; k++) begin
            v_sum = {1'b0, r_last} + GW1'(k);
            if (v_sum >= GW1'(N)) begin
                v_sum = v_sum - GW1'(N);
            end
            v_idx = v_sum[GW-1:0];
            if (!w_pick_any && w_miss[v_idx]) begin
                w_pick_any = 1'b1;
                w_pick     = v_idx;
            end
        end
    end

    // Bank word address of the picked client; wraps modulo 2^AW
    always_comb begin
        w_pick_addr = bus.addr[w_pick*AW +: AW];
        w_pick_off  = OFFSET[w_pick*AW +: AW];
        w_req_addr  = w_pick_off + (w_pick_addr << BSH);
    end

    // Beat assembly: DST restarts at slot 0, beats past the last slot are dropped
    always_comb begin
        w_beat_idx = bus.ba_dst ? '0 : r_beat;
        w_cap      = bus.ba_dok && (w_beat_idx < BW'(BEATS));
        w_buf_next = r_buf;
        for (int b = 0; b < BEATS; b++) begin
            if (w_cap && (w_beat_idx == BW'(b))) begin
                w_buf_next[b*16 +: 16] = bus.data_read;
            end
        end
    end

    assign bus.ba_addr = r_ba_addr;
    assign bus.ba_rd   = r_ba_rd;
    assign o_busy      = (r_state != S_IDLE);

    // Request FSM plus cache-entry update on transaction completion
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_valid   <= '0;
            r_gnt     <= '0;
            r_last    <= GW'(N - 1);
            r_laddr   <= '0;
            r_ba_addr <= '0;
            r_ba_rd   <= 1'b0;
            r_beat    <= '0;
            r_buf     <= '0;
            for (int i = 0; i < N; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (i_flush) begin
                r_valid <= '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (!i_downloading && w_pick_any) begin
                        r_gnt     <= w_pick;
                        r_laddr   <= w_pick_addr;
                        r_ba_addr <= w_req_addr;
                        r_ba_rd   <= 1'b1;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.ba_ack) begin
                        r_ba_rd <= 1'b0;
                        r_beat  <= '0;
                        // start from the old entry so uncaptured slots keep their data
                        r_buf   <= r_data[r_gnt];
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    r_buf <= w_buf_next;
                    if (w_cap) begin
                        r_beat <= w_beat_idx + 1'b1;
                    end else if (bus.ba_dst) begin
                        r_beat <= '0;
                    end
                    if (bus.ba_rdy) begin
                        r_data[r_gnt]  <= w_buf_next;
                        r_tag[r_gnt]   <= r_laddr;
                        // flush or an active download leaves the fresh entry invalid
                        r_valid[r_gnt] <= !i_downloading && !i_flush;
                        r_last         <= r_gnt;
                        r_state        <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_toaplan2_rom_arbiter.sv
// Self-checking bench for toaplan2_rom_arbiter: directed scenarios followed
// by randomized client traffic compared against a transaction-level cache model.
module tb_toaplan2_rom_arbiter;
    localparam int N  = 4;
    localparam int AW = 22;
    localparam int DW = 32;
    localparam logic [N*AW-1:0] OFFS = {22'h3FFFC0, 22'h000000, 22'h200000, 22'h100000};

    logic clk = 1'b0;
    logic rst;
    logic dl;
    logic flush;
    logic busy;

    toaplan2_rom_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

    toaplan2_rom_arbiter #(.N(N), .AW(AW), .DW(DW), .OFFSET(OFFS)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_downloading (dl),
        .i_flush       (flush),
        .o_busy        (busy),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0] off_tb [N] = '{22'h100000, 22'h200000, 22'h000000, 22'h3FFFC0};
    logic [AW-1:0] a_tb   [N];

    bit            mid_addr_en  = 0;
    logic [AW-1:0] mid_addr_val = '0;
    bit            flush_at_rdy = 0;
    bit            dl_after_ack = 0;

    // reference cache model for the random phase
    bit            m_valid [N];
    logic [AW-1:0] m_tag   [N];
    logic [DW-1:0] m_data  [N];
    int            m_last;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        a_tb[i] = a;
        bus.addr[i*AW +: AW] = a;
    endtask

    function automatic logic [AW-1:0] exp_ba(input int g, input logic [AW-1:0] a);
        logic [AW:0] s;
        s = {1'b0, off_tb[g]} + {a, 1'b0};
        return s[AW-1:0];
    endfunction

    // Plays the bank side of one transaction; entered in the cycle BA_RD should be high,
    // returns in the cycle after RDY.
    task automatic serve(input int g, input logic [AW-1:0] a, input logic [15:0] b0, input logic [15:0] b1);
        int d;
        check_val("ba_rd_req", bus.ba_rd, 1);
        check_val("ba_addr", bus.ba_addr, exp_ba(g, a));
        d = $urandom_range(0, 3);
        repeat (d) begin
            step();
            check_val("ba_rd_hold", bus.ba_rd, 1);
        end
        bus.ba_ack = 1;
        step();
        bus.ba_ack = 0;
        check_val("ba_rd_drop", bus.ba_rd, 0);
        if (mid_addr_en) set_addr(g, mid_addr_val);
        if (dl_after_ack) dl = 1;
        repeat ($urandom_range(0, 2)) step();
        bus.ba_dok = 1; bus.ba_dst = 1; bus.data_read = b0;
        step();
        bus.ba_dok = 0; bus.ba_dst = 0; bus.data_read = 16'($urandom);
        repeat ($urandom_range(0, 2)) step();
        bus.ba_dok = 1; bus.ba_rdy = 1; bus.data_read = b1;
        if (flush_at_rdy) flush = 1;
        step();
        bus.ba_dok = 0; bus.ba_rdy = 0; flush = 0;
        check_val("dout_fill", bus.dout[g*DW +: DW], {b1, b0});
        $display("txn client=%0d addr=%06h ba_addr=%06h data=%04h%04h", g, a, exp_ba(g, a), b1, b0);
    endtask

    task automatic do_reset();
        rst = 1; dl = 0; flush = 0;
        bus.cs = '0; bus.addr = '0;
        bus.ba_ack = 0; bus.ba_dst = 0; bus.ba_dok = 0; bus.ba_rdy = 0; bus.data_read = '0;
        for (int i = 0; i < N; i++) a_tb[i] = '0;
        step();
        step();
        rst = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] r0, r1;
        logic [N-1:0] e_ok;
        logic [N-1:0] e_miss;
        int g;

        // ---------------- reset state
        do_reset();
        check_val("rst_ba_rd", bus.ba_rd, 0);
        check_val("rst_ba_addr", bus.ba_addr, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ok", bus.ok, 0);
        for (int i = 0; i < N; i++) check_val("rst_dout", bus.dout[i*DW +: DW], 0);

        // ---------------- single client fill and hit
        set_addr(0, 22'h1234);
        bus.cs = 4'b0001;
        #1;
        check_val("t1_ok_miss", bus.ok, 0);
        step();
        check_val("t1_busy", busy, 1);
        check_val("t1_ba_addr_const", bus.ba_addr, 22'h102468);
        serve(0, 22'h1234, 16'hAAAA, 16'h5555);
        check_val("t1_dout_const", bus.dout[31:0], 32'h5555AAAA);
        check_val("t1_ok_after", bus.ok, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("t1_no_rd", bus.ba_rd, 0);
        end
        bus.cs = 4'b0000;
        step();
        bus.cs = 4'b0001;
        #1;
        check_val("t1_rehit", bus.ok, 4'b0001);
        step();
        check_val("t1_rehit_no_rd", bus.ba_rd, 0);

        // ---------------- fairness: 0,1,2,3 then 0 again
        do_reset();
        for (int i = 0; i < N; i++) set_addr(i, 22'h40 + AW'(i));
        bus.cs = 4'b1111;
        for (int k = 0; k < N; k++) begin
            step();
            if (k == 3) set_addr(0, 22'h99);
            r0 = 16'($urandom); r1 = 16'($urandom);
            serve(k, 22'h40 + AW'(k), r0, r1);
            e_ok = (k == 3) ? 4'b1110 : 4'((1 << (k + 1)) - 1);
            check_val("fair_ok", bus.ok, e_ok);
        end
        step();
        serve(0, 22'h99, 16'($urandom), 16'($urandom));
        check_val("fair_ok_all", bus.ok, 4'b1111);

        // ---------------- address change mid-fill
        bus.cs = 4'b0010;
        set_addr(1, 22'h10);
        #1;
        check_val("chg_ok_miss", bus.ok, 0);
        step();
        mid_addr_en = 1; mid_addr_val = 22'h11;
        serve(1, 22'h10, 16'h1111, 16'h2222);
        mid_addr_en = 0;
        check_val("chg_ok_low", bus.ok, 0);
        set_addr(1, 22'h10);
        #1;
        check_val("chg_tag_old", bus.ok, 4'b0010);
        set_addr(1, 22'h11);
        #1;
        check_val("chg_ok_new_miss", bus.ok, 0);
        step();
        serve(1, 22'h11, 16'h3333, 16'h4444);
        check_val("chg_ok_final", bus.ok, 4'b0010);

        // ---------------- flush coincident with RDY, then plain flush
        bus.cs = 4'b0100;
        set_addr(2, 22'h20);
        step();
        flush_at_rdy = 1;
        serve(2, 22'h20, 16'h0F0F, 16'hF0F0);
        flush_at_rdy = 0;
        check_val("flush_rdy_ok", bus.ok, 0);
        step();
        serve(2, 22'h20, 16'h0123, 16'h4567);
        check_val("flush_refill_ok", bus.ok, 4'b0100);
        flush = 1;
        step();
        flush = 0;
        check_val("flush_ok", bus.ok, 0);
        step();
        serve(2, 22'h20, 16'h89AB, 16'hCDEF);
        check_val("flush_refill2_ok", bus.ok, 4'b0100);

        // ---------------- downloading in IDLE
        dl = 1;
        bus.cs = 4'b1100;
        set_addr(3, 22'h30);
        #1;
        check_val("dl_ok_low", bus.ok, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("dl_no_rd", bus.ba_rd, 0);
            check_val("dl_not_busy", busy, 0);
        end
        dl = 0;
        #1;
        check_val("dl_off_ok", bus.ok, 4'b0100);
        step();
        serve(3, 22'h30, 16'h5A5A, 16'hA5A5);
        check_val("dl_resume_ok", bus.ok, 4'b1100);

        // ---------------- downloading mid-transaction
        set_addr(3, 22'h31);
        step();
        dl_after_ack = 1;
        serve(3, 22'h31, 16'h7777, 16'h8888);
        dl_after_ack = 0;
        check_val("dlmid_ok", bus.ok, 0);
        step();
        check_val("dlmid_no_rd", bus.ba_rd, 0);
        dl = 0;
        #1;
        check_val("dlmid_invalid", bus.ok, 4'b0100);
        step();
        serve(3, 22'h31, 16'h9999, 16'hBBBB);
        check_val("dlmid_refill_ok", bus.ok, 4'b1100);

        // ---------------- async reset mid-DATA
        set_addr(2, 22'h55);
        step();
        check_val("rstmid_rd", bus.ba_rd, 1);
        check_val("rstmid_addr", bus.ba_addr, exp_ba(2, 22'h55));
        bus.ba_ack = 1;
        step();
        bus.ba_ack = 0;
        bus.ba_dok = 1; bus.ba_dst = 1; bus.data_read = 16'h1234;
        step();
        bus.ba_dok = 0; bus.ba_dst = 0;
        check_val("rstmid_busy", busy, 1);
        check_val("rstmid_ok", bus.ok, 4'b1000);
        rst = 1;
        #1;
        check_val("rstmid_busy0", busy, 0);
        check_val("rstmid_ba_rd0", bus.ba_rd, 0);
        check_val("rstmid_ok0", bus.ok, 0);
        for (int i = 0; i < N; i++) check_val("rstmid_dout0", bus.dout[i*DW +: DW], 0);
        step();
        step();
        bus.cs = 4'b1111;
        rst = 0;
        step();
        serve(0, a_tb[0], 16'h4321, 16'h8765);
        check_val("rstmid_first_ok", bus.ok, 4'b0001);

        // ---------------- randomized traffic against the cache model
        do_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_tag[i] = '0; m_data[i] = '0;
        end
        m_last = N - 1;
        for (int it = 0; it < 80; it++) begin
            for (int i = 0; i < N; i++) begin
                bus.cs[i] = ($urandom_range(0, 3) != 0);
                set_addr(i, 22'h1E + AW'($urandom_range(0, 3)));
            end
            #1;
            for (int i = 0; i < N; i++) begin
                e_ok[i] = bus.cs[i] && m_valid[i] && (a_tb[i] == m_tag[i]);
                check_val("rnd_dout", bus.dout[i*DW +: DW], m_data[i]);
            end
            check_val("rnd_ok", bus.ok, e_ok);
            for (int t = 0; t <= N; t++) begin
                for (int i = 0; i < N; i++)
                    e_miss[i] = bus.cs[i] && !(m_valid[i] && (a_tb[i] == m_tag[i]));
                if (e_miss == '0) break;
                g = -1;
                for (int k = 1; k <= N; k++) begin
                    if (g < 0 && e_miss[(m_last + k) % N]) g = (m_last + k) % N;
                end
                step();
                r0 = 16'($urandom); r1 = 16'($urandom);
                serve(g, a_tb[g], r0, r1);
                m_valid[g] = 1; m_tag[g] = a_tb[g]; m_data[g] = {r1, r0}; m_last = g;
                for (int i = 0; i < N; i++)
                    e_ok[i] = bus.cs[i] && m_valid[i] && (a_tb[i] == m_tag[i]);
                check_val("rnd_ok_fill", bus.ok, e_ok);
            end
            step();
            check_val("rnd_idle_rd", bus.ba_rd, 0);
            if ($urandom_range(0, 7) == 0) begin
                flush = 1;
                step();
                flush = 0;
                for (int i = 0; i < N; i++) m_valid[i] = 0;
                check_val("rnd_flush_ok", bus.ok, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/toaplan2_rom_arbiter.md
# toaplan2_rom_arbiter

Parametrised SDRAM read arbiter and single-entry-per-client cache for one SDRAM bank, sitting between the per-game `*_sdram` wrapper's bank port and N ROM clients (68K program, tile/scroll GFX, PCM). It generalises the fixed per-client wiring to N clients with round-robin arbitration. It supports configurable client data width (16/32/64) assembled from 16-bit SDRAM beats and per-client base offsets. It adds hit detection, flush and download gating.

## Interface
- `N`, default 4: number of clients (2..8).
- `AW`, default 22: client and bank address width, in 16-bit words.
- `DW`, default 32: client data width; one of 16, 32, 64. BEATS = DW/16.
- `OFFSET`, default 0: N×AW packed; client i base word address is `OFFSET[i*AW +: AW]`.
- `CLK  in  1`: system clock. All logic is in this domain.
- `RESET  in  1`: asynchronous, active-high reset.
- `DOWNLOADING  in  1`: ROM load in progress. While high, no new requests are issued and all OK outputs are low.
- `FLUSH  in  1`: one-cycle pulse that clears all valid flags.
- `CS  in  N`: per-client read request, level.
- `ADDR  in  N*AW`: per-client address in DW-sized units. It is held stable while CS is high and the client is waiting.
- `OK  out  N`: DOUT[i] is valid for ADDR[i].
- `DOUT  out  N*DW`: per-client data.
- `BA_ADDR  out  AW`: bank word address.
- `BA_RD  out  1`: bank read request.
- `BA_ACK  in  1`: request accepted.
- `BA_DST  in  1`: first data beat.
- `BA_DOK  in  1`: DATA_READ is valid this cycle.
- `BA_RDY  in  1`: last beat; the transaction is done.
- `DATA_READ  in  16`: SDRAM data.
- `BUSY  out  1`: FSM is not in IDLE.

## Operation
- **Per-client state:** TAG[i] (AW bits), VALID[i], DATA[i] (DW bits).
- **OK[i]:** combinational, `CS[i] & VALID[i] & (ADDR[i]==TAG[i]) & ~DOWNLOADING`. DOUT[i] = DATA[i] at all times.
- **Miss[i]:** `CS[i] & ~(VALID[i] & ADDR[i]==TAG[i])`.
- **FSM IDLE:**
  - If `~DOWNLOADING` and any miss: pick the first missing client scanning from LAST+1 modulo N.
  - Latch its index into GNT and its ADDR into LADDR.
  - Compute `BA_ADDR = OFFSET[GNT] + (LADDR << log2(BEATS))`, truncated to AW bits (wraps modulo 2^AW).
  - Go to REQ.
- **FSM REQ:**
  - Hold BA_RD=1 with BA_ADDR stable.
  - On BA_ACK, drop BA_RD, clear BEAT, go to DATA.
- **FSM DATA:**
  - On each BA_DOK with BEAT<BEATS: store DATA_READ into slot BEAT (beat 0 → bits [15:0], ascending), then BEAT++. Extra DOK beats are ignored.
  - BA_DST resets BEAT to 0 before that cycle's capture.
  - On BA_RDY:
    - Write the assembled word to DATA[GNT] and LADDR to TAG[GNT].
    - Set VALID[GNT] = ~DOWNLOADING & ~FLUSH. Slots not captured keep their previous DATA.
    - Set LAST = GNT and return to IDLE.
- **ADDR or CS change mid-transaction:** the transaction completes and is stored under LADDR. The client then misses and is re-requested.
- **FLUSH:** clears all VALID in any state. If FLUSH coincides with BA_RDY, FLUSH wins and the entry ends invalid.
- **DOWNLOADING mid-transaction:** the transaction completes but the entry is stored invalid.

## Timing
- **Reset values:**
  - BA_RD=0, BA_ADDR=0, BUSY=0.
  - VALID=0, TAG=0, DATA=0, hence OK=0 and DOUT=0.
  - LAST=N-1, so client 0 has first priority.
  - State IDLE.
- **Hit:** OK in the same cycle ADDR/CS present (0 latency).
- **Miss:** miss sampled in IDLE at cycle t → BA_RD=1 from t+1.
- **Acknowledge:** BA_ACK at cycle k → BA_RD=0 at k+1.
- **Completion:** BA_RDY at cycle r → DATA/TAG/VALID updated and OK[GNT] high at r+1. IDLE re-arbitrates at r+1, so the next BA_RD is at r+2 at the earliest.
- **Bandwidth:** one outstanding transaction. BA_ADDR and BA_RD change only on clock edges.

## Test plan
- **Single client, DW=32, OFFSET[0]=0x100000:** CS0 with ADDR=0x1234 → BA_ADDR=0x102468, BA_RD until ACK. DOK beats 0xAAAA then 0x5555 with RDY on the second → DOUT0=0x5555AAAA and OK0 one cycle after RDY. A re-request of the same address gives OK0 immediately with no BA_RD.
- **Fairness:** all 4 clients miss continuously → grant order 0,1,2,3,0. No client is granted twice while another is pending.
- **Address change mid-fill:** client 1 ADDR changes 0x10→0x11 after ACK → entry stored with TAG 0x10 and OK1 stays low. A second transaction for 0x11 follows, after which OK1 goes high.
- **FLUSH coincident with RDY:** VALID ends 0 and the client re-requests.
- **DOWNLOADING:**
  - Asserted in IDLE: no BA_RD and all OK low.
  - Asserted mid-transaction: the transaction completes and the entry stays invalid.
  - After deassert: normal fetch resumes.
- **Reset mid-DATA:** async RESET → BA_RD=0 and OK=0 immediately, state IDLE. After release, client 0 is granted first.
